// File: rtl/io_handshake.sv
// I/O controller for LD/ST: LD stalls until the "go" button is pressed and released,
// then hands the captured switch value to the register file; ST latches a value onto the LEDs.
module io_handshake #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             read_in,
   input  logic             write_out,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [WIDTH-1:0] sw_data,
   input  logic             sw_go,
   output logic [WIDTH-1:0] rd_data,
   output logic             stall,
   output logic [WIDTH-1:0] leds
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_PRESS,
      WAIT_RELEASE,
      COMMIT
   } state_t;

   state_t           state_reg, state_next;
   logic             sync_reg [SYNC_STAGES];
   logic             go_s;
   logic             go_d_reg;
   logic             press;
   logic [WIDTH-1:0] rd_data_reg, rd_data_next;
   logic [WIDTH-1:0] leds_reg, leds_next;

   // Button synchronizer chain; stage 0 samples the asynchronous pin.
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (rst) sync_reg[gi] <= 1'b0;
               else     sync_reg[gi] <= sw_go;
            end
         end else begin : g_rest
            always_ff @(posedge clk) begin
               if (rst) sync_reg[gi] <= 1'b0;
               else     sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign go_s  = sync_reg[SYNC_STAGES-1];
   assign press = go_s & ~go_d_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         go_d_reg    <= 1'b0;
         state_reg   <= IDLE;
         rd_data_reg <= '0;
         leds_reg    <= '0;
      end else begin
         go_d_reg    <= go_s;
         state_reg   <= state_next;
         rd_data_reg <= rd_data_next;
         leds_reg    <= leds_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      rd_data_next = rd_data_reg;
      leds_next    = leds_reg;
      case (state_reg)
         IDLE: begin
            // LD wins over a simultaneous ST; the ST is dropped.
            if (read_in)        state_next = WAIT_PRESS;
            else if (write_out) leds_next  = wr_data;
         end
         WAIT_PRESS: begin
            if (press) begin
               rd_data_next = sw_data;
               state_next   = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (!go_s) state_next = COMMIT;
         end
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Combinational so the PC/register-file hold takes effect on the same edge.
   assign stall   = ((state_reg == IDLE) && read_in) ||
                    (state_reg == WAIT_PRESS) || (state_reg == WAIT_RELEASE);
   assign rd_data = rd_data_reg;
   assign leds    = leds_reg;

endmodule

// File: tb/tb_io_handshake.sv
// Bench for io_handshake: directed scenarios plus randomized LD/ST traffic, checked against
// expected timings derived from the synchronizer depth.
module tb_io_handshake;
   localparam int W = 8;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         read_in = 1'b0;
   logic         write_out = 1'b0;
   logic [W-1:0] wr_data = '0;
   logic [W-1:0] sw_data = '0;
   logic         sw_go = 1'b0;
   logic [W-1:0] rd_data;
   logic         stall;
   logic [W-1:0] leds;

   int           passed = 0;
   int           total = 0;
   logic [W-1:0] exp_rd = '0;
   logic [W-1:0] exp_leds = '0;

   io_handshake #(.WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .read_in(read_in), .write_out(write_out),
      .wr_data(wr_data), .sw_data(sw_data), .sw_go(sw_go),
      .rd_data(rd_data), .stall(stall), .leds(leds)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; read_in = 1'b0; write_out = 1'b0; sw_go = 1'b0;
      exp_rd = '0; exp_leds = '0;
      repeat (2) begin
         tick();
         total++; if (leds !== 8'h00) $display("FAIL reset_leds leds=%h expected 00", leds); else passed++;
         total++; if (rd_data !== 8'h00) $display("FAIL reset_rd rd_data=%h expected 00", rd_data); else passed++;
         total++; if (stall !== 1'b0) $display("FAIL reset_stall stall=%b expected 0", stall); else passed++;
      end
      read_in = 1'b1; #1;
      total++; if (stall !== 1'b1) $display("FAIL reset_stall_follows_read stall=%b expected 1", stall); else passed++;
      read_in = 1'b0; #1;
      rst = 1'b0;
   endtask

   task automatic test_single_st();
      write_out = 1'b1; wr_data = 8'hA5; #1;
      total++; if (stall !== 1'b0) $display("FAIL st_stall stall=%b expected 0", stall); else passed++;
      tick();
      exp_leds = 8'hA5;
      write_out = 1'b0; wr_data = 8'h00;
      total++; if (leds !== exp_leds) $display("FAIL st_leds leds=%h expected %h", leds, exp_leds); else passed++;
      tick();
      total++; if (leds !== exp_leds) $display("FAIL st_hold leds=%h expected %h", leds, exp_leds); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL st_stall_after stall=%b expected 0", stall); else passed++;
   endtask

   // Raise read_in, then spend pre cycles waiting; stray ST strobes here must be ignored.
   task automatic ld_start(input logic [W-1:0] data, input int pre);
      read_in = 1'b1; sw_data = data; #1;
      total++; if (stall !== 1'b1) $display("FAIL ld_first_stall stall=%b expected 1", stall); else passed++;
      for (int i = 0; i < pre; i++) begin
         write_out = 1'($urandom); wr_data = W'($urandom);
         tick();
         total++; if (stall !== 1'b1) $display("FAIL ld_wait_stall cyc=%0d stall=%b expected 1", i, stall); else passed++;
         total++; if (rd_data !== exp_rd) $display("FAIL ld_wait_rd cyc=%0d rd_data=%h expected %h", i, rd_data, exp_rd); else passed++;
         total++; if (leds !== exp_leds) $display("FAIL ld_st_ignored cyc=%0d leds=%h expected %h", i, leds, exp_leds); else passed++;
      end
      write_out = 1'b0;
   endtask

   // Button high on hold consecutive edges: capture lands S+1 edges after the rise,
   // COMMIT (stall low) S+1 edges after the fall.
   task automatic press_release(input logic [W-1:0] data, input int hold, input bit keep);
      int last;
      last = hold + S + 1;
      sw_data = data;
      sw_go = 1'b1;
      for (int t = 1; t <= last; t++) begin
         tick();
         if (t == S + 1) exp_rd = data;
         total++; if (rd_data !== exp_rd) $display("FAIL ld_capture t=%0d rd_data=%h expected %h", t, rd_data, exp_rd); else passed++;
         total++; if (stall !== (t != last)) $display("FAIL ld_stall t=%0d stall=%b expected %b", t, stall, (t != last)); else passed++;
         if (t >= S + 1) sw_data = W'($urandom);
         if (t == hold) sw_go = 1'b0;
      end
      if (!keep) read_in = 1'b0;
      tick();
      total++; if (stall !== keep) $display("FAIL ld_after_commit stall=%b expected %b", stall, keep); else passed++;
      total++; if (rd_data !== exp_rd) $display("FAIL ld_rd_hold rd_data=%h expected %h", rd_data, exp_rd); else passed++;
   endtask

   task automatic test_basic_ld();
      ld_start(8'h3C, 5);
      press_release(8'h3C, 6, 1'b0);
   endtask

   task automatic test_button_held();
      sw_go = 1'b1;
      repeat (S + 2) tick();
      ld_start(8'h11, 6);
      sw_go = 1'b0;
      for (int i = 0; i < S + 2; i++) begin
         tick();
         total++; if (stall !== 1'b1) $display("FAIL held_stall cyc=%0d stall=%b expected 1", i, stall); else passed++;
         total++; if (rd_data !== exp_rd) $display("FAIL held_no_capture cyc=%0d rd_data=%h expected %h", i, rd_data, exp_rd); else passed++;
      end
      press_release(8'h11, 3, 1'b0);
   endtask

   task automatic test_collision();
      test_reset();
      read_in = 1'b1; write_out = 1'b1; wr_data = 8'hFF;
      tick();
      write_out = 1'b0;
      total++; if (leds !== 8'h00) $display("FAIL collision_leds leds=%h expected 00", leds); else passed++;
      total++; if (stall !== 1'b1) $display("FAIL collision_stall stall=%b expected 1", stall); else passed++;
      press_release(8'hC3, 2, 1'b0);
   endtask

   task automatic test_reset_mid_ld();
      ld_start(8'h77, 1);
      sw_go = 1'b1;
      repeat (S + 1) tick();
      exp_rd = 8'h77;
      total++; if (rd_data !== exp_rd) $display("FAIL midrst_capture rd_data=%h expected %h", rd_data, exp_rd); else passed++;
      tick();
      rst = 1'b1; sw_go = 1'b0;
      tick();
      rst = 1'b0;
      exp_rd = '0; exp_leds = '0;
      total++; if (rd_data !== 8'h00) $display("FAIL midrst_rd rd_data=%h expected 00", rd_data); else passed++;
      total++; if (leds !== 8'h00) $display("FAIL midrst_leds leds=%h expected 00", leds); else passed++;
      total++; if (stall !== 1'b1) $display("FAIL midrst_stall stall=%b expected 1", stall); else passed++;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (stall !== 1'b1) $display("FAIL midrst_wait cyc=%0d stall=%b expected 1", i, stall); else passed++;
         total++; if (rd_data !== 8'h00) $display("FAIL midrst_nocap cyc=%0d rd_data=%h expected 00", i, rd_data); else passed++;
      end
      press_release(8'h5A, 2, 1'b0);
   endtask

   task automatic test_back_to_back();
      ld_start(8'h01, 2);
      press_release(8'h01, 3, 1'b1);
      ld_start(8'h02, 3);
      press_release(8'h02, 2, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            int cnt;
            cnt = $urandom_range(1, 3);
            write_out = 1'b1;
            for (int k = 0; k < cnt; k++) begin
               wr_data = W'($urandom); sw_go = 1'($urandom);
               exp_leds = wr_data;
               tick();
               total++; if (leds !== exp_leds) $display("FAIL rnd_st n=%0d leds=%h expected %h", n, leds, exp_leds); else passed++;
               total++; if (stall !== 1'b0) $display("FAIL rnd_st_stall n=%0d stall=%b expected 0", n, stall); else passed++;
            end
            write_out = 1'b0; wr_data = W'($urandom); sw_go = 1'b0;
            repeat (S + 1) tick();
            total++; if (leds !== exp_leds) $display("FAIL rnd_st_hold n=%0d leds=%h expected %h", n, leds, exp_leds); else passed++;
         end else begin
            logic [W-1:0] d;
            d = W'($urandom);
            ld_start(d, $urandom_range(0, 5));
            press_release(d, $urandom_range(1, 6), 1'b0);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_st();
      test_basic_ld();
      test_button_held();
      test_collision();
      test_reset_mid_ld();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/io_handshake.md
# io_handshake

Synchronous I/O controller that executes the LD and ST instructions flagged by the instruction decoder. It sits directly downstream of the decoder and consumes its `read_in` and `write_out` strobes. On LD it stalls the processor until the user presses and releases the external "go" button, then supplies the sampled switch value to the register-file write path. On ST it latches a register value onto the LED outputs in a single cycle, with no stall.

## Interface
- `WIDTH`, default 8: data width of the switches, LEDs and register data.
- `SYNC_STAGES`, default 2 (minimum 2): number of synchronizer flops on `sw_go`.

Ports:
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `read_in`, input, 1: LD in progress, from the decoder; held for the whole instruction.
- `write_out`, input, 1: ST in progress, from the decoder.
- `wr_data`, input, WIDTH: register-file read value to be output on ST.
- `sw_data`, input, WIDTH: external switches; assumed quasi-static while the button is pressed.
- `sw_go`, input, 1: external asynchronous handshake button, active-high.
- `rd_data`, output, WIDTH: registered switch value, fed to the register-file write mux when LD completes.
- `stall`, output, 1: combinational; high means PC and register-file writes must hold.
- `leds`, output, WIDTH: registered output port.

## Operation
**Synchronizer**
- `sw_go` passes through `SYNC_STAGES` flops to give `go_s`.
- One further flop gives `go_d`.
- `press = go_s & ~go_d`.

**State machine** (IDLE, WAIT_PRESS, WAIT_RELEASE, COMMIT)
- IDLE:
  - If `read_in`, go to WAIT_PRESS.
  - Else if `write_out`, set `leds <= wr_data` and stay in IDLE.
- WAIT_PRESS: on `press`, set `rd_data <= sw_data` and go to WAIT_RELEASE.
  - A button already held when WAIT_PRESS is entered produces no `press`. It must be released and pressed again.
- WAIT_RELEASE: when `go_s == 0`, go to COMMIT.
- COMMIT: lasts one cycle with stall low, so the LD writes `rd_data` and the PC advances. Then go to IDLE unconditionally.

**Stall**
- `stall = (IDLE & read_in) | WAIT_PRESS | WAIT_RELEASE`.
- `stall` is 0 in COMMIT and is 0 in IDLE when no LD is present.

**Boundary and priority rules**
- `read_in` and `write_out` both high in IDLE: LD has priority; `leds` is unchanged.
- `write_out` outside IDLE is ignored. This cannot legally occur while stalled.
- Back-to-back LDs: COMMIT returns to IDLE. The next LD, now seen in IDLE, restarts the handshake. A new press-and-release is required for each LD.
- Back-to-back STs: `leds` updates on every cycle in which `write_out` is high in IDLE.
- `rd_data` holds its value between LDs. `leds` holds until the next ST.
- Button activity during IDLE or COMMIT is ignored apart from keeping the synchronizer current.

## Timing
- **Reset values:** state = IDLE, `rd_data = 0`, `leds = 0`, all synchronizer flops and `go_d` = 0. `stall` then equals `read_in`.
- **Reset mid-operation** (any state): the next edge returns to IDLE with the above values. A held `read_in` restarts the LD from WAIT_PRESS. A captured but uncommitted `rd_data` is discarded.
- **ST latency:** `leds` shows `wr_data` one cycle after the edge on which `write_out` is sampled in IDLE.
- **LD latency from `sw_go` rising** (stable, in WAIT_PRESS): `press` is seen `SYNC_STAGES` cycles later, and `rd_data` is valid on the following edge.
- **LD latency from `sw_go` falling:** WAIT_RELEASE exits after `SYNC_STAGES` cycles, then COMMIT lasts 1 cycle.
- **Minimum LD duration:** 1 (IDLE) + press path + release path + 1 (COMMIT).
- `stall` has no registered delay relative to state; the consumer samples it on the same edge.

## Test plan
- **Reset and single ST:** `rst` high 2 cycles, then low; apply `write_out=1`, `wr_data=8'hA5` for 1 cycle. Required: `leds=0` during reset, `leds=8'hA5` the next cycle, `stall=0` throughout.
- **Basic LD:** `read_in=1`, `sw_data=8'h3C`; raise `sw_go` 5 cycles later and hold 6 cycles, then lower it. Required:
  - `stall=1` from the first cycle.
  - `rd_data=8'h3C` exactly `SYNC_STAGES+1` cycles after the `sw_go` rise.
  - COMMIT (`stall=0`) `SYNC_STAGES+1` cycles after the `sw_go` fall, then IDLE.
- **Button held at LD start:** `sw_go=1` before `read_in` rises; `sw_data=8'h11`. Required: no capture and `stall` stays 1 until `sw_go` falls and rises again; `rd_data` then becomes 8'h11.
- **LD/ST collision:** `read_in=1`, `write_out=1`, `wr_data=8'hFF` in IDLE. Required: `leds` stays 0 and the FSM enters WAIT_PRESS.
- **Reset mid-LD:** assert `rst` in WAIT_RELEASE after capturing 8'h77. Required: `rd_data=0`, state IDLE, and with `read_in` still high, `stall=1` and a fresh press is needed.
- **Back-to-back LDs** with `sw_data` 8'h01 then 8'h02 and two separate press/release pairs. Required: two COMMIT cycles, `rd_data` 8'h01 then 8'h02, one press per LD.
